push_stack_unit: RTL and testbench
==================================

PUSH_STACK_UNIT -- requirements
Module: push_stack_unit

Interface
REQ-001 Parameter WIDTH, 16, data width of all value ports and stack entries (>= 8).
REQ-002 Parameter DEPTH, 8, stack entries (power of two, >= 2).
REQ-003 Parameter SHAMT_W, 4, shift-amount width (2**SHAMT_W <= WIDTH).
REQ-004 clk  in  1  single rising-edge clock.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 push_src  in  3  source select: 000 alu_out, 001 b_val, 010 shift_q, 011 mem_out, 100 zero-extended ir[7:0], 101 se_val, 110/111 top.
REQ-007 alu_out, b_val, a_val, mem_out, se_val  in  WIDTH  datapath operands.
REQ-008 ir  in  16  instruction register.
REQ-009 shift_en  in  1  capture shifter result into shift_q.
REQ-010 shift_dir  in  1  0 left, 1 right.
REQ-011 shamt_src  in  1  0 shamt = ir[SHAMT_W+1:2], 1 shamt = b_val[SHAMT_W-1:0].
REQ-012 shift_rot  in  1  rotate instead of logical shift (see Configuration).
REQ-013 push, pop  in  1  stack operation requests, one per cycle.
REQ-014 push_val  out  WIDTH  combinational selected push value.
REQ-015 top  out  WIDTH  registered top-of-stack entry.
REQ-016 count  out  $clog2(DEPTH)+1  occupancy.
REQ-017 full, empty  out  1  occupancy flags.
REQ-018 overflow, underflow  out  1  sticky error flags.

Function
REQ-019 push_val SHALL equal the push_src-selected source in the same cycle; zero-extension fills bits WIDTH-1:8 with 0.
REQ-020 Shifter SHALL shift a_val by shamt; logical shifts fill zeros; shamt 0 passes a_val unchanged.
REQ-021 shift_q SHALL load the shifter result on the edge where shift_en=1 and hold otherwise (one-cycle latency).
REQ-022 push with !full SHALL write push_val at index count, increment count, update top to push_val next cycle.
REQ-023 pop with !empty SHALL decrement count; top SHALL show entry count-2 next cycle, or 0 if stack becomes empty.
REQ-024 push and pop together with !empty SHALL replace the top entry with push_val, count unchanged.
REQ-025 push and pop together when empty SHALL act as push only; underflow not set.
REQ-026 push when full (without pop) SHALL be dropped, contents unchanged, overflow set.
REQ-027 pop when empty (without push) SHALL be dropped, underflow set.
REQ-028 push_src=11x with push SHALL duplicate the top value (dup) under the same rules.
REQ-029 full = (count==DEPTH); empty = (count==0); both derived from registered count.
REQ-030 overflow/underflow SHALL clear only on reset.

Reset
REQ-031 While reset=0 at an edge: count=0, top=0, shift_q=0, overflow=0, underflow=0; push/pop/shift_en ignored that cycle.
REQ-032 Reset mid-sequence SHALL discard all stack contents; entry storage need not be cleared.

Configuration
REQ-033 Macro PUSH_STACK_ROTATE_EN defined: shift_rot=1 makes the shifter rotate in shift_dir by shamt.
REQ-034 PUSH_STACK_ROTATE_EN undefined: shift_rot ignored, logical shifts only; port remains present.

Structure
REQ-035 Shared package push_stack_pkg SHALL hold push_src encodings and shift-direction constants.
REQ-036 One sub-module push_shifter (combinational, WIDTH/SHAMT_W parametrised, rotate under the macro); stack storage, count and flags stay in push_stack_unit.

Verification (WIDTH=16, DEPTH=8)
REQ-037 ir=0x12ab, push_src=100 -> push_val=0x00ab; push -> top=0x00ab, count=1 next cycle.
REQ-038 a_val=0xffdd, ir=0x000d, shamt_src=0, shift_en=1; dir left -> shift_q=0xfee8; dir right -> 0x1ffb; dir right + shift_rot with macro -> 0xbffb, without -> 0x1ffb.
REQ-039 9 consecutive pushes of 1..9 -> count=8, full=1, top=8, overflow=1; pop -> top=7, count=7.
REQ-040 Empty stack, pop -> underflow=1, count=0; push+pop with top=0x0005, alu_out=0x0042, push_src=000 -> top=0x0042, count unchanged.
REQ-041 Push 3 values, assert reset=0 one cycle -> count=0, empty=1, top=0, flags 0; next push 0x00aa -> top=0x00aa, count=1.

Source files
------------

// File: rtl/push_stack_pkg.sv
// Shared encodings for the push-stack datapath: push source selects and shift directions.
package push_stack_pkg;

  typedef enum logic [2:0] {
    SRC_ALU   = 3'b000,
    SRC_B     = 3'b001,
    SRC_SHIFT = 3'b010,
    SRC_MEM   = 3'b011,
    SRC_IMM   = 3'b100,
    SRC_SE    = 3'b101,
    SRC_TOP   = 3'b110,
    SRC_DUP   = 3'b111
  } pushSrcE;

  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

endpackage

// File: rtl/push_stack_unit_if.sv
// Operand, control and status bundle between a driving datapath and push_stack_unit.
interface push_stack_unit_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [2:0]       push_src;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] b_val;
  logic [WIDTH-1:0] a_val;
  logic [WIDTH-1:0] mem_out;
  logic [WIDTH-1:0] se_val;
  logic [15:0]      ir;
  logic             shift_en;
  logic             shift_dir;
  logic             shamt_src;
  logic             shift_rot;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] push_val;
  logic [WIDTH-1:0] top;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output push_src, alu_out, b_val, a_val, mem_out, se_val, ir,
           shift_en, shift_dir, shamt_src, shift_rot, push, pop,
    input  push_val, top, count, full, empty, overflow, underflow
  );

  modport slave (
    input  push_src, alu_out, b_val, a_val, mem_out, se_val, ir,
           shift_en, shift_dir, shamt_src, shift_rot, push, pop,
    output push_val, top, count, full, empty, overflow, underflow
  );

endinterface

// File: rtl/push_shifter.sv
// Combinational barrel shifter for the push datapath; rotation exists only when
// PUSH_STACK_ROTATE_EN is defined, otherwise rot is ignored.
module push_shifter
  import push_stack_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               dir,
  input  logic               rot,
  output logic [WIDTH-1:0]   dout
);

  logic [WIDTH-1:0] logicalLeft;
  logic [WIDTH-1:0] logicalRight;

  assign logicalLeft  = din << shamt;
  assign logicalRight = din >> shamt;

`ifdef PUSH_STACK_ROTATE_EN
  logic [WIDTH-1:0] rotLeft;
  logic [WIDTH-1:0] rotRight;

  // Shifting by WIDTH yields zero, so shamt 0 still passes din through untouched.
  assign rotLeft  = logicalLeft  | (din >> (WIDTH - int'(shamt)));
  assign rotRight = logicalRight | (din << (WIDTH - int'(shamt)));

  always_comb begin
    dout = logicalLeft;
    if (rot) begin
      dout = (dir == SHIFT_RIGHT) ? rotRight : rotLeft;
    end else begin
      dout = (dir == SHIFT_RIGHT) ? logicalRight : logicalLeft;
    end
  end
`else
  logic unusedRot;
  assign unusedRot = rot;

  always_comb begin
    dout = (dir == SHIFT_RIGHT) ? logicalRight : logicalLeft;
  end
`endif

endmodule

// File: rtl/push_stack_unit.sv
// Push-source mux, shift register and LIFO stack with sticky overflow/underflow flags.
// Rotation support in the shifter is enabled by defining PUSH_STACK_ROTATE_EN.
module push_stack_unit
  import push_stack_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int SHAMT_W = 4
) (
  input logic              clk,
  input logic              reset,
  push_stack_unit_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [CNT_W-1:0]   countQ;
  logic [WIDTH-1:0]   topQ;
  logic [WIDTH-1:0]   shiftQ;
  logic               overflowQ;
  logic               underflowQ;

  logic [WIDTH-1:0]   pushVal;
  logic [WIDTH-1:0]   shiftRes;
  logic [SHAMT_W-1:0] shamt;
  pushSrcE            srcSel;
  logic               isFull;
  logic               isEmpty;

  logic               memWe;
  logic [ADDR_W-1:0]  memAddr;
  logic [ADDR_W-1:0]  belowIdx;
  logic [CNT_W-1:0]   countNext;
  logic [WIDTH-1:0]   topNext;
  logic               setOverflow;
  logic               setUnderflow;

  logic               unusedIrHigh;
  assign unusedIrHigh = ^bus.ir[15:8];

  assign isFull   = (countQ == CNT_W'(DEPTH));
  assign isEmpty  = (countQ == '0);
  assign belowIdx = countQ[ADDR_W-1:0] - ADDR_W'(2);
  assign srcSel   = pushSrcE'(bus.push_src);
  assign shamt    = bus.shamt_src ? bus.b_val[SHAMT_W-1:0] : bus.ir[SHAMT_W+1:2];

  always_comb begin
    pushVal = topQ;
    case (srcSel)
      SRC_ALU:   pushVal = bus.alu_out;
      SRC_B:     pushVal = bus.b_val;
      SRC_SHIFT: pushVal = shiftQ;
      SRC_MEM:   pushVal = bus.mem_out;
      SRC_IMM:   pushVal = {{(WIDTH-8){1'b0}}, bus.ir[7:0]};
      SRC_SE:    pushVal = bus.se_val;
      default:   pushVal = topQ;
    endcase
  end

  push_shifter #(
    .WIDTH  (WIDTH),
    .SHAMT_W(SHAMT_W)
  ) shifter (
    .din  (bus.a_val),
    .shamt(shamt),
    .dir  (bus.shift_dir),
    .rot  (bus.shift_rot),
    .dout (shiftRes)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      shiftQ <= '0;
    end else if (bus.shift_en) begin
      shiftQ <= shiftRes;
    end
  end

  // Push+pop on a non-empty stack overwrites the top slot; on an empty stack it is a plain push.
  always_comb begin
    memWe        = 1'b0;
    memAddr      = countQ[ADDR_W-1:0];
    countNext    = countQ;
    topNext      = topQ;
    setOverflow  = 1'b0;
    setUnderflow = 1'b0;
    if (bus.push && bus.pop && !isEmpty) begin
      memWe   = 1'b1;
      memAddr = countQ[ADDR_W-1:0] - 1'b1;
      topNext = pushVal;
    end else if (bus.push) begin
      if (isFull) begin
        setOverflow = 1'b1;
      end else begin
        memWe     = 1'b1;
        countNext = countQ + 1'b1;
        topNext   = pushVal;
      end
    end else if (bus.pop) begin
      if (isEmpty) begin
        setUnderflow = 1'b1;
      end else begin
        countNext = countQ - 1'b1;
        topNext   = (countQ == CNT_W'(1)) ? '0 : mem[belowIdx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && memWe) begin
      mem[memAddr] <= pushVal;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      countQ     <= '0;
      topQ       <= '0;
      overflowQ  <= 1'b0;
      underflowQ <= 1'b0;
    end else begin
      countQ     <= countNext;
      topQ       <= topNext;
      overflowQ  <= overflowQ | setOverflow;
      underflowQ <= underflowQ | setUnderflow;
    end
  end

  assign bus.push_val  = pushVal;
  assign bus.top       = topQ;
  assign bus.count     = countQ;
  assign bus.full      = isFull;
  assign bus.empty     = isEmpty;
  assign bus.overflow  = overflowQ;
  assign bus.underflow = underflowQ;

endmodule

// File: tb/tb_push_stack_unit.sv
// Directed self-checking bench for push_stack_unit (WIDTH=16, DEPTH=8).
module tb_push_stack_unit;

  logic clk;
  logic reset;
  int   assertCount;
  int   failCount;

  push_stack_unit_if #(.WIDTH(16), .DEPTH(8)) bus ();

  push_stack_unit #(.WIDTH(16), .DEPTH(8), .SHAMT_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one edge and settle so outputs are sampled well away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic doPush, input logic doPop,
                               input logic [2:0] src, input logic [15:0] alu);
    bus.push     = doPush;
    bus.pop      = doPop;
    bus.push_src = src;
    bus.alu_out  = alu;
    tick();
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  logic [15:0] rotExpect;

  initial begin
    assertCount   = 0;
    failCount     = 0;
    reset         = 1'b0;
    bus.push_src  = 3'b000;
    bus.alu_out   = '0;
    bus.b_val     = '0;
    bus.a_val     = '0;
    bus.mem_out   = '0;
    bus.se_val    = '0;
    bus.ir        = '0;
    bus.shift_en  = 1'b0;
    bus.shift_dir = 1'b0;
    bus.shamt_src = 1'b0;
    bus.shift_rot = 1'b0;
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    tick();
    tick();
    reset = 1'b1;

    checkOutput("rst_count", 32'(bus.count), 32'd0);
    checkOutput("rst_empty", 32'(bus.empty), 32'd1);
    checkOutput("rst_full", 32'(bus.full), 32'd0);
    checkOutput("rst_top", 32'(bus.top), 32'h0);
    checkOutput("rst_ovf", 32'(bus.overflow), 32'd0);
    checkOutput("rst_unf", 32'(bus.underflow), 32'd0);

    bus.alu_out = 16'h1111;
    bus.b_val   = 16'h2222;
    bus.mem_out = 16'h4444;
    bus.se_val  = 16'h5555;
    bus.ir      = 16'h12ab;
    bus.push_src = 3'b000; #1; checkOutput("src_alu", 32'(bus.push_val), 32'h1111);
    bus.push_src = 3'b001; #1; checkOutput("src_b", 32'(bus.push_val), 32'h2222);
    bus.push_src = 3'b011; #1; checkOutput("src_mem", 32'(bus.push_val), 32'h4444);
    bus.push_src = 3'b101; #1; checkOutput("src_se", 32'(bus.push_val), 32'h5555);
    bus.push_src = 3'b110; #1; checkOutput("src_top_empty", 32'(bus.push_val), 32'h0);
    bus.push_src = 3'b100; #1; checkOutput("src_imm", 32'(bus.push_val), 32'h00ab);

    applyStimulus(1'b1, 1'b0, 3'b100, 16'h1111);
    checkOutput("imm_push_top", 32'(bus.top), 32'h00ab);
    checkOutput("imm_push_count", 32'(bus.count), 32'd1);

    bus.a_val     = 16'hffdd;
    bus.ir        = 16'h000d;
    bus.shamt_src = 1'b0;
    bus.shift_en  = 1'b1;
    bus.push_src  = 3'b010;
    bus.shift_dir = 1'b0;
    tick();
    checkOutput("shl3", 32'(bus.push_val), 32'hfee8);
    bus.shift_dir = 1'b1;
    tick();
    checkOutput("shr3", 32'(bus.push_val), 32'h1ffb);
    bus.shift_rot = 1'b1;
    tick();
`ifdef PUSH_STACK_ROTATE_EN
    rotExpect = 16'hbffb;
`else
    rotExpect = 16'h1ffb;
`endif
    checkOutput("rotr3", 32'(bus.push_val), 32'(rotExpect));
    bus.shift_rot = 1'b0;
    bus.shift_en  = 1'b0;
    bus.shift_dir = 1'b0;
    bus.a_val     = 16'h0f0f;
    tick();
    checkOutput("shift_hold", 32'(bus.push_val), 32'(rotExpect));
    bus.shamt_src = 1'b1;
    bus.b_val     = 16'h0010;
    bus.a_val     = 16'h1234;
    bus.shift_en  = 1'b1;
    tick();
    checkOutput("shamt0_pass", 32'(bus.push_val), 32'h1234);
    bus.b_val     = 16'h0004;
    tick();
    checkOutput("shl_bval4", 32'(bus.push_val), 32'h2340);
    bus.shift_en  = 1'b0;

    doReset();
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b1, 1'b0, 3'b000, 16'(i));
    end
    checkOutput("fill_count", 32'(bus.count), 32'd8);
    checkOutput("fill_full", 32'(bus.full), 32'd1);
    checkOutput("fill_top", 32'(bus.top), 32'd8);
    checkOutput("fill_ovf", 32'(bus.overflow), 32'd1);
    checkOutput("fill_unf", 32'(bus.underflow), 32'd0);
    applyStimulus(1'b0, 1'b1, 3'b000, 16'h0);
    checkOutput("pop_top", 32'(bus.top), 32'd7);
    checkOutput("pop_count", 32'(bus.count), 32'd7);
    checkOutput("pop_full", 32'(bus.full), 32'd0);
    applyStimulus(1'b1, 1'b0, 3'b111, 16'h0);
    checkOutput("dup_top", 32'(bus.top), 32'd7);
    checkOutput("dup_count", 32'(bus.count), 32'd8);
    applyStimulus(1'b0, 1'b1, 3'b000, 16'h0);
    checkOutput("undup_top", 32'(bus.top), 32'd7);
    applyStimulus(1'b0, 1'b1, 3'b000, 16'h0);
    checkOutput("pop2_top", 32'(bus.top), 32'd6);
    checkOutput("pop2_count", 32'(bus.count), 32'd6);

    doReset();
    applyStimulus(1'b0, 1'b1, 3'b000, 16'h0);
    checkOutput("unf_flag", 32'(bus.underflow), 32'd1);
    checkOutput("unf_count", 32'(bus.count), 32'd0);
    applyStimulus(1'b1, 1'b0, 3'b000, 16'h0005);
    checkOutput("pre_swap_top", 32'(bus.top), 32'h0005);
    applyStimulus(1'b1, 1'b1, 3'b000, 16'h0042);
    checkOutput("swap_top", 32'(bus.top), 32'h0042);
    checkOutput("swap_count", 32'(bus.count), 32'd1);
    applyStimulus(1'b0, 1'b1, 3'b000, 16'h0);
    checkOutput("drain_top", 32'(bus.top), 32'h0);
    checkOutput("drain_empty", 32'(bus.empty), 32'd1);

    doReset();
    applyStimulus(1'b1, 1'b1, 3'b000, 16'h0077);
    checkOutput("pp_empty_top", 32'(bus.top), 32'h0077);
    checkOutput("pp_empty_count", 32'(bus.count), 32'd1);
    checkOutput("pp_empty_unf", 32'(bus.underflow), 32'd0);

    doReset();
    applyStimulus(1'b1, 1'b0, 3'b000, 16'h0011);
    applyStimulus(1'b1, 1'b0, 3'b000, 16'h0022);
    applyStimulus(1'b1, 1'b0, 3'b000, 16'h0033);
    checkOutput("pre_rst_count", 32'(bus.count), 32'd3);
    reset    = 1'b0;
    bus.push = 1'b1;
    bus.alu_out = 16'h0044;
    tick();
    bus.push = 1'b0;
    reset    = 1'b1;
    checkOutput("midrst_count", 32'(bus.count), 32'd0);
    checkOutput("midrst_empty", 32'(bus.empty), 32'd1);
    checkOutput("midrst_top", 32'(bus.top), 32'h0);
    checkOutput("midrst_ovf", 32'(bus.overflow), 32'd0);
    checkOutput("midrst_unf", 32'(bus.underflow), 32'd0);
    applyStimulus(1'b1, 1'b0, 3'b000, 16'h00aa);
    checkOutput("post_rst_top", 32'(bus.top), 32'h00aa);
    checkOutput("post_rst_count", 32'(bus.count), 32'd1);
    applyStimulus(1'b0, 1'b1, 3'b000, 16'h0);
    checkOutput("post_rst_pop_top", 32'(bus.top), 32'h0);
    checkOutput("post_rst_pop_unf", 32'(bus.underflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
